// File: rtl/id_pipe_stage_pkg.sv
// Shared decode constants for the ID pipeline stage: opcode values and prefixes,
// control-word layout and memory access size encodings.
package id_pkg;

  localparam int SIZE_W = 3;
  localparam int CTRL_W = 8 + SIZE_W;

  // Control word bit positions, MSB first:
  // {alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, signed, word_size}
  localparam int CB_WSIZE_LSB  = 0;
  localparam int CB_SIGNED     = 3;
  localparam int CB_JUMP       = 4;
  localparam int CB_BRANCH     = 5;
  localparam int CB_REG_WRITE  = 6;
  localparam int CB_MEM_TO_REG = 7;
  localparam int CB_MEM_WRITE  = 8;
  localparam int CB_MEM_READ   = 9;
  localparam int CB_ALU_SRC    = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [2:0] OP_LOAD_PFX   = 3'b100;
  localparam logic [2:0] OP_STORE_PFX  = 3'b101;
  localparam logic [2:0] OP_IMM_PFX    = 3'b001;
  localparam logic [3:0] OP_ZEXT_PFX   = 4'b0011;
  localparam logic [4:0] OP_BRANCH_PFX = 5'b00010;

  localparam logic [SIZE_W-1:0] WS_BYTE = 3'd0;
  localparam logic [SIZE_W-1:0] WS_HALF = 3'd1;
  localparam logic [SIZE_W-1:0] WS_WORD = 3'd3;

  localparam logic [4:0] RA_REG = 5'd31;

endpackage

// File: rtl/id_pipe_stage_hazard_detector.sv
// Load-use hazard detection for the decode stage. A flush wins over a stall;
// o_bubble tells the ID/EX register to load an empty slot.
module hazard_detector #(
  parameter int REGS = 5
) (
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic            i_ex_mem_read,
  input  logic [REGS-1:0] i_ex_reg_dir,
  input  logic [REGS-1:0] i_dir_rs,
  input  logic [REGS-1:0] i_dir_rt,
  output logic            o_stall,
  output logic            o_bubble
);

  logic w_load_use;

  assign w_load_use = i_valid && i_ex_mem_read && (i_ex_reg_dir != '0) &&
                      ((i_ex_reg_dir == i_dir_rs) || (i_ex_reg_dir == i_dir_rt));
  assign o_stall    = w_load_use && !i_flush;
  assign o_bubble   = i_flush || w_load_use || !i_valid;

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction decode stage: register file, control decode, load-use hazard check
// and the ID/EX pipeline register. Define ID_WB_BYPASS_EN to forward same-cycle writeback data to reads.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int NB           = 32,
  parameter int REGS         = 5,
  parameter int CTRLNB       = 6,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_valid,
  input  logic [NB-1:0]     i_instruction,
  input  logic [NB-1:0]     i_pc4,
  input  logic              i_wb_reg_write,
  input  logic [REGS-1:0]   i_wb_reg_dir,
  input  logic [NB-1:0]     i_wb_data,
  input  logic              i_ex_mem_read,
  input  logic [REGS-1:0]   i_ex_reg_dir,
  input  logic              i_flush,
  input  logic [REGS-1:0]   i_dbg_reg_sel,
  output logic [NB-1:0]     o_dbg_reg_data,
  output logic              o_stall,
  output logic              o_valid,
  output logic [NB-1:0]     o_data_a,
  output logic [NB-1:0]     o_data_b,
  output logic [NB-1:0]     o_imm,
  output logic [NB-1:0]     o_shamt,
  output logic [CTRLNB-1:0] o_opcode,
  output logic [CTRLNB-1:0] o_funct,
  output logic [REGS-1:0]   o_dir_rs,
  output logic [REGS-1:0]   o_dir_rt,
  output logic [REGS-1:0]   o_reg_dir_to_write,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [NB-1:0]     o_jump_addr
);

  localparam int NREGS = 2 ** REGS;

  logic [NB-1:0]     r_regs [NREGS];

  logic [CTRLNB-1:0] w_op;
  logic [CTRLNB-1:0] w_funct;
  logic [REGS-1:0]   w_rs;
  logic [REGS-1:0]   w_rt;
  logic [REGS-1:0]   w_rd;
  logic [15:0]       w_imm16;
  logic [NB-1:0]     w_imm;
  logic [NB-1:0]     w_shamt;
  logic [NB-1:0]     w_jump_addr;
  logic [CTRL_W-1:0] w_ctrl;
  logic [REGS-1:0]   w_dest;
  logic [NB_SIZE_TYPE-1:0] w_wsize;
  logic              w_wb_en;
  logic [NB-1:0]     w_rs_data;
  logic [NB-1:0]     w_rt_data;
  logic [NB-1:0]     w_dbg_data;
  logic              w_stall;
  logic              w_bubble;
  logic              w_unused_pc;

  assign w_op        = i_instruction[31:26];
  assign w_rs        = i_instruction[25:21];
  assign w_rt        = i_instruction[20:16];
  assign w_rd        = i_instruction[15:11];
  assign w_funct     = i_instruction[5:0];
  assign w_imm16     = i_instruction[15:0];
  assign w_shamt     = NB'(i_instruction[10:6]);
  assign w_jump_addr = {i_pc4[NB-1:NB-4], i_instruction[25:0], 2'b00};
  assign w_wsize     = NB_SIZE_TYPE'(w_op[1:0]);
  assign w_unused_pc = &{1'b0, i_pc4[NB-5:0]};

  assign w_wb_en = i_step && i_wb_reg_write && (i_wb_reg_dir != '0);

  always_comb begin
    w_ctrl = '0;
    w_dest = '0;
    if (w_op == OP_RTYPE) begin
      w_ctrl[CB_REG_WRITE] = 1'b1;
      w_dest               = w_rd;
    end else if (w_op[5:3] == OP_LOAD_PFX) begin
      w_ctrl[CB_MEM_READ]   = 1'b1;
      w_ctrl[CB_MEM_TO_REG] = 1'b1;
      w_ctrl[CB_REG_WRITE]  = 1'b1;
      w_ctrl[CB_ALU_SRC]    = 1'b1;
      w_ctrl[CB_SIGNED]     = !w_op[2];
      w_ctrl[CB_WSIZE_LSB +: SIZE_W] = SIZE_W'(w_wsize);
      w_dest                = w_rt;
    end else if (w_op[5:3] == OP_STORE_PFX) begin
      w_ctrl[CB_MEM_WRITE] = 1'b1;
      w_ctrl[CB_ALU_SRC]   = 1'b1;
    end else if (w_op[5:3] == OP_IMM_PFX) begin
      w_ctrl[CB_REG_WRITE] = 1'b1;
      w_ctrl[CB_ALU_SRC]   = 1'b1;
      w_dest               = w_rt;
    end else if (w_op[5:1] == OP_BRANCH_PFX) begin
      w_ctrl[CB_BRANCH] = 1'b1;
    end else if (w_op == OP_J) begin
      w_ctrl[CB_JUMP] = 1'b1;
    end else if (w_op == OP_JAL) begin
      w_ctrl[CB_JUMP]      = 1'b1;
      w_ctrl[CB_REG_WRITE] = 1'b1;
      w_dest               = REGS'(RA_REG);
    end
  end

  // Logical immediates zero-extend; lui places the immediate in the upper half.
  always_comb begin
    if (w_op == OP_LUI) begin
      w_imm = NB'({w_imm16, 16'h0000});
    end else if (w_op[5:2] == OP_ZEXT_PFX) begin
      w_imm = NB'(w_imm16);
    end else begin
      w_imm = {{(NB-16){w_imm16[15]}}, w_imm16};
    end
  end

  always_comb begin
    w_rs_data  = (w_rs == '0) ? '0 : r_regs[w_rs];
    w_rt_data  = (w_rt == '0) ? '0 : r_regs[w_rt];
    w_dbg_data = (i_dbg_reg_sel == '0) ? '0 : r_regs[i_dbg_reg_sel];
`ifdef ID_WB_BYPASS_EN
    if (w_wb_en && (i_wb_reg_dir == w_rs))          w_rs_data  = i_wb_data;
    if (w_wb_en && (i_wb_reg_dir == w_rt))          w_rt_data  = i_wb_data;
    if (w_wb_en && (i_wb_reg_dir == i_dbg_reg_sel)) w_dbg_data = i_wb_data;
`endif
  end

  assign o_dbg_reg_data = w_dbg_data;

  hazard_detector #(
    .REGS (REGS)
  ) u_hazard (
    .i_valid       (i_valid),
    .i_flush       (i_flush),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_reg_dir  (i_ex_reg_dir),
    .i_dir_rs      (w_rs),
    .i_dir_rt      (w_rt),
    .o_stall       (w_stall),
    .o_bubble      (w_bubble)
  );

  assign o_stall = w_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[i_wb_reg_dir] <= i_wb_data;
    end
  end

  // A bubble keeps the decoded payload but clears everything that has an effect downstream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid            <= 1'b0;
      o_data_a           <= '0;
      o_data_b           <= '0;
      o_imm              <= '0;
      o_shamt            <= '0;
      o_opcode           <= '0;
      o_funct            <= '0;
      o_dir_rs           <= '0;
      o_dir_rt           <= '0;
      o_reg_dir_to_write <= '0;
      o_ctrl             <= '0;
      o_jump_addr        <= '0;
    end else if (i_step) begin
      o_valid            <= !w_bubble;
      o_data_a           <= w_rs_data;
      o_data_b           <= w_rt_data;
      o_imm              <= w_imm;
      o_shamt            <= w_shamt;
      o_opcode           <= w_op;
      o_funct            <= w_funct;
      o_dir_rs           <= w_rs;
      o_dir_rt           <= w_rt;
      o_reg_dir_to_write <= w_bubble ? '0 : w_dest;
      o_ctrl             <= w_bubble ? '0 : w_ctrl;
      o_jump_addr        <= w_jump_addr;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: decode, hazard/flush bubbles, register file,
// step hold and reset behaviour, with hand-computed expectations.
module tb_id_pipe_stage;

  localparam int NB     = 32;
  localparam int REGS   = 5;
  localparam int CTRLNB = 6;
  localparam int CW     = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              step;
  logic              valid;
  logic [NB-1:0]     instr;
  logic [NB-1:0]     pc4;
  logic              wb_write;
  logic [REGS-1:0]   wb_dir;
  logic [NB-1:0]     wb_data;
  logic              ex_mem_read;
  logic [REGS-1:0]   ex_dir;
  logic              flush;
  logic [REGS-1:0]   dbg_sel;
  logic [NB-1:0]     dbg_data;
  logic              stall;
  logic              o_valid;
  logic [NB-1:0]     data_a;
  logic [NB-1:0]     data_b;
  logic [NB-1:0]     imm;
  logic [NB-1:0]     shamt;
  logic [CTRLNB-1:0] opcode;
  logic [CTRLNB-1:0] funct;
  logic [REGS-1:0]   dir_rs;
  logic [REGS-1:0]   dir_rt;
  logic [REGS-1:0]   dest;
  logic [CW-1:0]     ctrl;
  logic [NB-1:0]     jump_addr;

  int n_total = 0;
  int n_bad   = 0;

  id_pipe_stage dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_step             (step),
    .i_valid            (valid),
    .i_instruction      (instr),
    .i_pc4              (pc4),
    .i_wb_reg_write     (wb_write),
    .i_wb_reg_dir       (wb_dir),
    .i_wb_data          (wb_data),
    .i_ex_mem_read      (ex_mem_read),
    .i_ex_reg_dir       (ex_dir),
    .i_flush            (flush),
    .i_dbg_reg_sel      (dbg_sel),
    .o_dbg_reg_data     (dbg_data),
    .o_stall            (stall),
    .o_valid            (o_valid),
    .o_data_a           (data_a),
    .o_data_b           (data_b),
    .o_imm              (imm),
    .o_shamt            (shamt),
    .o_opcode           (opcode),
    .o_funct            (funct),
    .o_dir_rs           (dir_rs),
    .o_dir_rt           (dir_rt),
    .o_reg_dir_to_write (dest),
    .o_ctrl             (ctrl),
    .o_jump_addr        (jump_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    step        = 1'b1;
    valid       = 1'b0;
    instr       = '0;
    pc4         = '0;
    wb_write    = 1'b0;
    wb_dir      = '0;
    wb_data     = '0;
    ex_mem_read = 1'b0;
    ex_dir      = '0;
    flush       = 1'b0;
    dbg_sel     = '0;
  endtask

  task automatic wb_write_reg(input logic [REGS-1:0] dir, input logic [NB-1:0] data);
    valid    = 1'b0;
    wb_write = 1'b1;
    wb_dir   = dir;
    wb_data  = data;
    tick();
    wb_write = 1'b0;
  endtask

  task automatic issue(input logic [NB-1:0] word);
    valid = 1'b1;
    instr = word;
    tick();
  endtask

  // Decode table: instruction, control word, destination, immediate
  logic [NB-1:0]   t_instr [9];
  logic [CW-1:0]   t_ctrl  [9];
  logic [REGS-1:0] t_dest  [9];
  logic [NB-1:0]   t_imm   [9];

  initial begin
    t_instr[0] = 32'h8C27FFFC; t_ctrl[0] = 11'h6CB; t_dest[0] = 5'd7; t_imm[0] = 32'hFFFFFFFC; // lw
    t_instr[1] = 32'h90270000; t_ctrl[1] = 11'h6C0; t_dest[1] = 5'd7; t_imm[1] = 32'h00000000; // lbu
    t_instr[2] = 32'h84270002; t_ctrl[2] = 11'h6C9; t_dest[2] = 5'd7; t_imm[2] = 32'h00000002; // lh
    t_instr[3] = 32'h34088000; t_ctrl[3] = 11'h440; t_dest[3] = 5'd8; t_imm[3] = 32'h00008000; // ori
    t_instr[4] = 32'h3C091234; t_ctrl[4] = 11'h440; t_dest[4] = 5'd9; t_imm[4] = 32'h12340000; // lui
    t_instr[5] = 32'hAC220008; t_ctrl[5] = 11'h500; t_dest[5] = 5'd0; t_imm[5] = 32'h00000008; // sw
    t_instr[6] = 32'h1044FFFF; t_ctrl[6] = 11'h020; t_dest[6] = 5'd0; t_imm[6] = 32'hFFFFFFFF; // beq
    t_instr[7] = 32'h08000010; t_ctrl[7] = 11'h010; t_dest[7] = 5'd0; t_imm[7] = 32'h00000010; // j
    t_instr[8] = 32'hFC000000; t_ctrl[8] = 11'h000; t_dest[8] = 5'd0; t_imm[8] = 32'h00000000; // unknown

    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_ctrl", 64'(ctrl), 64'd0);
    check_eq("rst_dest", 64'(dest), 64'd0);
    check_eq("rst_jump", 64'(jump_addr), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);

    wb_write_reg(5'd2, 32'h00000011);
    wb_write_reg(5'd4, 32'h00000022);
    wb_write_reg(5'd5, 32'h00000055);
    dbg_sel = 5'd2;
    #1 check_eq("dbg_r2", 64'(dbg_data), 64'h11);

    // addi r1,r0,5
    issue(32'h20010005);
    check_eq("addi_valid", 64'(o_valid), 64'd1);
    check_eq("addi_ctrl", 64'(ctrl), 64'h440);
    check_eq("addi_dest", 64'(dest), 64'd1);
    check_eq("addi_imm", 64'(imm), 64'd5);

    // add r3,r2,r4 without hazard
    issue(32'h00441820);
    check_eq("add_a", 64'(data_a), 64'h11);
    check_eq("add_b", 64'(data_b), 64'h22);
    check_eq("add_ctrl", 64'(ctrl), 64'h040);
    check_eq("add_dest", 64'(dest), 64'd3);
    check_eq("add_funct", 64'(funct), 64'h20);

    // load-use hazard on rs, then rt, then the r0 and invalid boundaries
    ex_mem_read = 1'b1;
    ex_dir      = 5'd2;
    #1 check_eq("haz_stall_rs", 64'(stall), 64'd1);
    tick();
    check_eq("haz_bub_valid", 64'(o_valid), 64'd0);
    check_eq("haz_bub_ctrl", 64'(ctrl), 64'd0);
    check_eq("haz_bub_dest", 64'(dest), 64'd0);
    ex_dir = 5'd4;
    #1 check_eq("haz_stall_rt", 64'(stall), 64'd1);
    ex_dir = 5'd3;
    #1 check_eq("haz_other_reg", 64'(stall), 64'd0);
    ex_dir = 5'd0;
    instr  = 32'h00003020;
    #1 check_eq("haz_r0", 64'(stall), 64'd0);
    ex_dir = 5'd2;
    instr  = 32'h00441820;
    valid  = 1'b0;
    #1 check_eq("haz_invalid", 64'(stall), 64'd0);
    valid  = 1'b1;
    ex_mem_read = 1'b0;
    #1 check_eq("haz_no_load", 64'(stall), 64'd0);

    // flush overrides stall
    ex_mem_read = 1'b1;
    flush       = 1'b1;
    #1 check_eq("flush_stall", 64'(stall), 64'd0);
    tick();
    check_eq("flush_valid", 64'(o_valid), 64'd0);
    check_eq("flush_ctrl", 64'(ctrl), 64'd0);
    flush       = 1'b0;
    ex_mem_read = 1'b0;

    // same-cycle writeback of r5 while reading r5
    instr    = 32'h00A03020;
    wb_write = 1'b1;
    wb_dir   = 5'd5;
    wb_data  = 32'hDEADBEEF;
    tick();
    wb_write = 1'b0;
`ifdef ID_WB_BYPASS_EN
    check_eq("wb_same_cycle", 64'(data_a), 64'hDEADBEEF);
`else
    check_eq("wb_same_cycle", 64'(data_a), 64'h55);
`endif
    tick();
    check_eq("wb_next_cycle", 64'(data_a), 64'hDEADBEEF);

    // write to r0 is dropped
    instr    = 32'h00003020;
    wb_write = 1'b1;
    wb_dir   = 5'd0;
    wb_data  = 32'hFFFFFFFF;
    tick();
    wb_write = 1'b0;
    check_eq("r0_same_cycle", 64'(data_a), 64'd0);
    dbg_sel = 5'd0;
    tick();
    check_eq("r0_read", 64'(data_a), 64'd0);
    check_eq("r0_dbg", 64'(dbg_data), 64'd0);

    for (int i = 0; i < 9; i++) begin
      issue(t_instr[i]);
      check_eq($sformatf("dec%0d_ctrl", i), 64'(ctrl), 64'(t_ctrl[i]));
      check_eq($sformatf("dec%0d_dest", i), 64'(dest), 64'(t_dest[i]));
      check_eq($sformatf("dec%0d_imm", i), 64'(imm), 64'(t_imm[i]));
    end

    // sll r3,r2,7 then hold with step low
    issue(32'h000219C0);
    check_eq("sll_shamt", 64'(shamt), 64'd7);
    check_eq("sll_b", 64'(data_b), 64'h11);
    step    = 1'b0;
    dbg_sel = 5'd2;
    for (int c = 0; c < 3; c++) begin
      instr    = 32'h3C090000 | 32'(c + 1);
      wb_write = 1'b1;
      wb_dir   = 5'd2;
      wb_data  = 32'h99 + 32'(c);
      tick();
      check_eq($sformatf("hold%0d_shamt", c), 64'(shamt), 64'd7);
      check_eq($sformatf("hold%0d_dest", c), 64'(dest), 64'd3);
      check_eq($sformatf("hold%0d_ctrl", c), 64'(ctrl), 64'h040);
      check_eq($sformatf("hold%0d_reg", c), 64'(dbg_data), 64'h11);
    end
    wb_write    = 1'b0;
    instr       = 32'h00441820;
    ex_mem_read = 1'b1;
    ex_dir      = 5'd4;
    #1 check_eq("hold_stall_comb", 64'(stall), 64'd1);
    ex_mem_read = 1'b0;
    step        = 1'b1;

    // jal 0x0000100
    pc4 = 32'h40000004;
    issue(32'h0C000100);
    check_eq("jal_addr", 64'(jump_addr), 64'h40000400);
    check_eq("jal_dest", 64'(dest), 64'd31);
    check_eq("jal_ctrl", 64'(ctrl), 64'h050);

    // reset while a hazard is present
    instr       = 32'h00441820;
    ex_mem_read = 1'b1;
    ex_dir      = 5'd2;
    reset       = 1'b1;
    step        = 1'b0;
    tick();
    check_eq("rst2_valid", 64'(o_valid), 64'd0);
    check_eq("rst2_jump", 64'(jump_addr), 64'd0);
    check_eq("rst2_dest", 64'(dest), 64'd0);
    check_eq("rst2_reg", 64'(dbg_data), 64'd0);
    check_eq("rst2_stall", 64'(stall), 64'd1);
    ex_mem_read = 1'b0;
    #1 check_eq("rst2_stall_clr", 64'(stall), 64'd0);
    reset = 1'b0;
    step  = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 Parameters, one per line: NB=32, data/instruction width; REGS=5, register address width (2**REGS registers); CTRLNB=6, opcode/funct width; NB_SIZE_TYPE=3, memory access size field width.
REQ-002 Ports, one per line (name direction width meaning): i_clk in 1 clock; i_reset in 1 reset; i_step in 1 advance enable; i_valid in 1 instruction valid; i_instruction in NB fetched word; i_pc4 in NB PC+4; i_wb_reg_write in 1 writeback enable; i_wb_reg_dir in REGS writeback address; i_wb_data in NB writeback data; i_ex_mem_read in 1 EX-stage instruction is a load; i_ex_reg_dir in REGS EX-stage destination; i_flush in 1 squash decode; i_dbg_reg_sel in REGS debug register select; o_dbg_reg_data out NB debug register value; o_stall out 1 hold IF and IF/ID; o_valid out 1 ID/EX entry valid; o_data_a out NB rs value; o_data_b out NB rt value; o_imm out NB extended immediate; o_shamt out NB zero-extended shamt; o_opcode out CTRLNB; o_funct out CTRLNB; o_dir_rs out REGS; o_dir_rt out REGS; o_reg_dir_to_write out REGS; o_ctrl out CTRL_W packed control {alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, signed, word_size}; o_jump_addr out NB.
REQ-003 One clock, i_clk; reset i_reset is synchronous and active-high.

Function
REQ-004 All o_* except o_stall and o_dbg_reg_data SHALL be registered (ID/EX register); latency i_instruction -> outputs is 1 cycle when i_step=1.
REQ-005 When i_step=0, ID/EX register and register file SHALL hold; o_stall still evaluates combinationally.
REQ-006 Decode: op=0 -> reg_write, dest rd; op 100xxx -> mem_read, mem_to_reg, reg_write, alu_src, dest rt, word_size from op[1:0], signed=!op[2]; op 101xxx -> mem_write, alu_src; op 001xxx -> reg_write, alu_src, dest rt; op 00010x -> branch; op 000010 -> jump; op 000011 -> jump, reg_write, dest 31; other opcodes -> all control zero.
REQ-007 o_imm: zero-extended for op 0011xx except 001111 (lui: imm<<16); sign-extended otherwise.
REQ-008 o_jump_addr = {i_pc4[NB-1:NB-4], instr[25:0], 2'b00}.
REQ-009 Load-use hazard: o_stall=1 when i_valid && i_ex_mem_read && i_ex_reg_dir!=0 && i_ex_reg_dir in {rs, rt}, and i_flush=0.
REQ-010 On stall (with i_step=1), ID/EX SHALL load a bubble: o_valid=0, o_ctrl=0, o_reg_dir_to_write=0; instruction reissued next cycle by upstream hold.
REQ-011 i_flush has priority over stall: bubble loaded, o_stall=0.
REQ-012 i_valid=0 SHALL load a bubble.
REQ-013 Register file: write at clock edge when i_step && i_wb_reg_write && i_wb_reg_dir!=0; register 0 reads 0 always.
REQ-014 o_dbg_reg_data = combinational read of register i_dbg_reg_sel, unaffected by stall/flush.

Reset
REQ-015 On i_reset all ID/EX outputs SHALL be 0 (o_valid=0) and all registers cleared to 0; reset overrides i_step.
REQ-016 Reset asserted mid-stall SHALL deassert o_stall only through ID/EX clear and normal REQ-009 evaluation.

Configuration
REQ-017 Macro ID_WB_BYPASS_EN: defined -> read of rs/rt/debug address equal to a same-cycle valid write (REQ-013 conditions) returns i_wb_data; undefined -> returns stored value (write visible next cycle).

Structure
REQ-018 Package id_pkg holds opcode constants, CTRL_W, control bit index constants and word_size encodings.
REQ-019 One sub-module hazard_detector implementing REQ-009/REQ-011; register array inline.

Verification
REQ-020 Reset then addi r1,r0,5 with step -> next cycle o_valid=1, reg_write=1, alu_src=1, o_reg_dir_to_write=1, o_imm=5.
REQ-021 i_ex_mem_read=1, i_ex_reg_dir=2, instr add r3,r2,r4 -> o_stall=1, next cycle o_valid=0, o_ctrl=0.
REQ-022 Same as REQ-021 with i_flush=1 -> o_stall=0, bubble loaded.
REQ-023 WB write r5=0xDEADBEEF same cycle as read of r5: with ID_WB_BYPASS_EN o_data_a=0xDEADBEEF next cycle; without, old value; write to r0 -> r0 reads 0.
REQ-024 i_step=0 for 3 cycles with changing i_instruction -> outputs and registers unchanged; jal 0x0000100 with i_pc4=0x40000004 -> o_jump_addr=0x40000400, dest 31.
